// File: rtl/writeback_arbiter_pkg.sv
// Shared writeback pipeline definitions: unit codes, result entry layout and
// the per-unit buffer depth used by the writeback arbiter and its FIFOs.
package writeback_arbiter_pkg;

  localparam int WB_FIFO_DEPTH = 2;
  localparam int WB_REG_W      = 5;
  localparam int WB_DATA_W     = 32;

  typedef enum logic [1:0] {
    UNIT_AM   = 2'b00,
    UNIT_MEM  = 2'b01,
    UNIT_MUL  = 2'b10,
    UNIT_IDLE = 2'b11
  } wb_unit_t;

  typedef struct packed {
    logic [WB_REG_W-1:0]  regdest;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  // Round-robin successor over the three real units.
  function automatic wb_unit_t wb_next_unit(input wb_unit_t u);
    case (u)
      UNIT_AM:  return UNIT_MEM;
      UNIT_MEM: return UNIT_MUL;
      default:  return UNIT_AM;
    endcase
  endfunction

endpackage

// File: rtl/writeback_arbiter_result_fifo.sv
// Two-entry result buffer for one execution unit; ready depends only on the
// registered count so a full buffer never accepts, even alongside a pop.
module wb_result_fifo
  import writeback_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  wb_entry_t  push_entry,
  input  logic       pop,
  output wb_entry_t  head,
  output logic [1:0] count,
  output logic       ready
);

  wb_entry_t entries [WB_FIFO_DEPTH];
  logic      rd_ptr;
  logic      wr_ptr;
  logic      do_push;
  logic      do_pop;

  assign ready   = (count != 2'(WB_FIFO_DEPTH));
  assign do_push = push && ready;
  assign do_pop  = pop && (count != 2'd0);
  assign head    = entries[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: the count gates every read of it.
  always_ff @(posedge clock) begin
    if (do_push) entries[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: buffers results from AluMisc, Mem and Mult units and
// retires one per cycle, round-robin, to the register file and scoreboard.
//
// last_grant | meaning
// UNIT_AM    | AluMisc retired last, Mem searched first
// UNIT_MEM   | Mem retired last, Mult searched first
// UNIT_MUL   | Mult retired last (also reset), AluMisc searched first
module writeback_arbiter
  import writeback_arbiter_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        am_wb_valid,
  input  logic [4:0]  am_wb_regdest,
  input  logic        am_wb_writereg,
  input  logic [31:0] am_wb_data,
  input  logic        mem_wb_valid,
  input  logic [4:0]  mem_wb_regdest,
  input  logic        mem_wb_writereg,
  input  logic [31:0] mem_wb_data,
  input  logic        mul_wb_valid,
  input  logic [4:0]  mul_wb_regdest,
  input  logic        mul_wb_writereg,
  input  logic [31:0] mul_wb_data,
  output logic        wb_am_ready,
  output logic        wb_mem_ready,
  output logic        wb_mul_ready,
  output logic        wb_reg_write,
  output logic [4:0]  wb_reg_addr,
  output logic [31:0] wb_reg_data,
  output logic        wb_sb_release,
  output logic [4:0]  wb_sb_addr,
  output logic [1:0]  wb_sb_unit,
  output logic        wb_busy
);

  wb_entry_t  fifo_head  [3];
  wb_entry_t  fifo_in    [3];
  logic [1:0] fifo_count [3];
  logic [2:0] fifo_ready;
  logic [2:0] fifo_push;
  logic [2:0] fifo_pop;

  wb_unit_t   last_grant;
  wb_unit_t   cand;
  wb_unit_t   grant_unit;
  logic       grant_valid;
  wb_entry_t  grant_entry;
  wb_unit_t   out_unit;

  // Results that do not write the register file are dropped at the door.
  assign fifo_push[0] = am_wb_valid  && am_wb_writereg;
  assign fifo_push[1] = mem_wb_valid && mem_wb_writereg;
  assign fifo_push[2] = mul_wb_valid && mul_wb_writereg;

  assign fifo_in[0] = '{regdest: am_wb_regdest,  data: am_wb_data};
  assign fifo_in[1] = '{regdest: mem_wb_regdest, data: mem_wb_data};
  assign fifo_in[2] = '{regdest: mul_wb_regdest, data: mul_wb_data};

  for (genvar u = 0; u < 3; u++) begin : g_fifo
    wb_result_fifo u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push       (fifo_push[u]),
      .push_entry (fifo_in[u]),
      .pop        (fifo_pop[u]),
      .head       (fifo_head[u]),
      .count      (fifo_count[u]),
      .ready      (fifo_ready[u])
    );
  end

  assign wb_am_ready  = fifo_ready[0];
  assign wb_mem_ready = fifo_ready[1];
  assign wb_mul_ready = fifo_ready[2];
  assign wb_busy      = (fifo_count[0] != 2'd0) || (fifo_count[1] != 2'd0) ||
                        (fifo_count[2] != 2'd0);
  assign wb_sb_unit   = out_unit;

  always_comb begin
    grant_valid = 1'b0;
    grant_unit  = UNIT_IDLE;
    cand        = last_grant;
    for (int i = 0; i < 3; i++) begin
      cand = wb_next_unit(cand);
      if (!grant_valid) begin
        case (cand)
          UNIT_AM:  if (fifo_count[0] != 2'd0) begin grant_valid = 1'b1; grant_unit = cand; end
          UNIT_MEM: if (fifo_count[1] != 2'd0) begin grant_valid = 1'b1; grant_unit = cand; end
          UNIT_MUL: if (fifo_count[2] != 2'd0) begin grant_valid = 1'b1; grant_unit = cand; end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    fifo_pop    = 3'b000;
    grant_entry = '0;
    case (grant_unit)
      UNIT_AM:  begin fifo_pop = 3'b001; grant_entry = fifo_head[0]; end
      UNIT_MEM: begin fifo_pop = 3'b010; grant_entry = fifo_head[1]; end
      UNIT_MUL: begin fifo_pop = 3'b100; grant_entry = fifo_head[2]; end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant    <= UNIT_MUL;
      wb_reg_write  <= 1'b0;
      wb_sb_release <= 1'b0;
      wb_reg_addr   <= 5'd0;
      wb_reg_data   <= 32'd0;
      wb_sb_addr    <= 5'd0;
      out_unit      <= UNIT_IDLE;
    end else begin
      wb_sb_release <= grant_valid;
      // r0 is hardwired: release the scoreboard row but skip the ARF write.
      wb_reg_write  <= grant_valid && (grant_entry.regdest != 5'd0);
      if (grant_valid) begin
        last_grant  <= grant_unit;
        wb_reg_addr <= grant_entry.regdest;
        wb_reg_data <= grant_entry.data;
        wb_sb_addr  <= grant_entry.regdest;
        out_unit    <= grant_unit;
      end
    end
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have `clock`, input, 1, rising-edge clock.
REQ-002 SHALL have `reset`, input, 1, asynchronous, active-low reset.
REQ-003 SHALL have, for u in {am, mem, mul}, `<u>_wb_valid`, input, 1, result present.
REQ-004 SHALL have `<u>_wb_regdest`, input, 5, destination register.
REQ-005 SHALL have `<u>_wb_writereg`, input, 1, result writes the register file.
REQ-006 SHALL have `<u>_wb_data`, input, 32, result value.
REQ-007 SHALL have `wb_<u>_ready`, output, 1, buffer can accept a result.
REQ-008 SHALL have `wb_reg_write`, output, 1, ARF write enable.
REQ-009 SHALL have `wb_reg_addr`, output, 5, ARF write address.
REQ-010 SHALL have `wb_reg_data`, output, 32, ARF write data.
REQ-011 SHALL have `wb_sb_release`, output, 1, clear scoreboard row.
REQ-012 SHALL have `wb_sb_addr`, output, 5, scoreboard row to clear.
REQ-013 SHALL have `wb_sb_unit`, output, 2, releasing unit: 00 AluMisc, 01 Mem, 10 Mult.
REQ-014 SHALL have `wb_busy`, output, 1, at least one buffer non-empty.

Function
REQ-015 SHALL give each unit a private 2-entry FIFO of {regdest, data}.
REQ-016 SHALL accept a result when valid && ready && writereg at a rising edge; valid && ready && !writereg SHALL be discarded with no enqueue and no release.
REQ-017 SHALL drive ready = (count != 2) from registered count only; push while full SHALL NOT occur, even with a same-cycle pop.
REQ-018 SHALL, on simultaneous push and pop, leave count unchanged and preserve FIFO order.
REQ-019 SHALL grant at most one non-empty FIFO per cycle, round-robin, searching from last_grant+1 mod 3.
REQ-020 SHALL pop the granted head at the edge and register it to the outputs; outputs valid for exactly one cycle per grant.
REQ-021 SHALL make a result accepted at edge k visible on outputs after edge k+1 at earliest (1-cycle latency).
REQ-022 SHALL, per grant, assert wb_sb_release=1 with wb_sb_addr=regdest and wb_sb_unit=unit code.
REQ-023 SHALL, per grant, assert wb_reg_write=1 with addr and data, except when regdest=0: then wb_reg_write=0 but wb_sb_release still 1.
REQ-024 SHALL hold addr, data and unit at last values when write and release are low; enables SHALL be 0 when no grant.
REQ-025 SHALL sustain one retire per cycle while any FIFO is non-empty (no bubbles).
REQ-026 SHALL compute wb_busy = OR of count != 0 across the three FIFOs.

Reset
REQ-027 SHALL, on reset low, asynchronously clear all FIFO counts and pointers.
REQ-028 SHALL, on reset low, set wb_reg_write=0, wb_sb_release=0, wb_reg_addr=0, wb_reg_data=0, wb_sb_addr=0 and wb_sb_unit=2'b11.
REQ-029 SHALL, on reset low, set last_grant=Mult so the first grant favours AluMisc.
REQ-030 SHALL drop buffered results on reset mid-operation with no release emitted.
REQ-031 SHALL drive all ready outputs 1 from the first edge after reset deassertion.

Structure
REQ-032 SHALL place unit codes (00/01/10/11 idle) and the FIFO depth constant (2) in the shared pipeline package.
REQ-033 SHALL use one sub-module `wb_result_fifo` (2-entry, 37-bit, count/ready), instantiated three times; arbitration and output registers live in the top.

Verification
REQ-034 SHALL test: am valid, regdest=5, data=0xDEADBEEF, writereg=1 at edge 0 -> after edge 1 write=1, addr=5, data=0xDEADBEEF, release=1, unit=00 for one cycle.
REQ-035 SHALL test: am, mem and mul each push 1 entry in the same cycle -> retire order am, mem, mul on 3 consecutive cycles; wb_busy low after the third.
REQ-036 SHALL test: mul pushes 3 back-to-back while am is saturated -> wb_mul_ready low after 2 entries; grants alternate; no entry lost or reordered.
REQ-037 SHALL test: mem result with regdest=0 -> wb_reg_write=0, wb_sb_release=1, wb_sb_addr=0, unit=01.
REQ-038 SHALL test: mem result with writereg=0 -> no output activity; count stays 0.
REQ-039 SHALL test: reset asserted with 2 entries buffered -> all enables 0, wb_sb_unit=11, readies 1, no release after deassertion.
